// File: rtl/avst_chan_pkg.sv
// Shared types and constants for the Avalon-ST channel adapter family:
// packet FSM states, drop-counter sizing and the default-width beat record.
package avst_chan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } chan_state_e;

    localparam int unsigned                  DROP_CNT_W   = 16;
    localparam logic [DROP_CNT_W-1:0]        DROP_CNT_MAX = '1;

    // Beat layout for the default 8-bit data / 8-bit channel configuration.
    localparam int unsigned BEAT_DATA_W    = 8;
    localparam int unsigned BEAT_CHANNEL_W = 8;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0]    data;
        logic [BEAT_CHANNEL_W-1:0] channel;
        logic                      sop;
        logic                      eop;
    } beat_t;

endpackage

// File: rtl/avst_skid_buffer.sv
// Two-entry Avalon-ST skid buffer with a registered ready (no combinational
// path from out_ready to in_ready) and a registered output payload.
module avst_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    assign in_ready  = ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
        // A pop in the same cycle as the filling push is only seen next cycle.
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage is reset too so out_data reads zero after reset; non-blocking throughout.
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

endmodule

// File: rtl/avst_channel_mux_adapter.sv
// Avalon-ST channel adapter: maps in_channel + CHANNEL_OFFSET onto a wider
// channel, locks it per packet, drops out-of-range packets. Optional
// protocol checker enabled by macro AVST_PKT_CHECK_EN.
module avst_channel_mux_adapter
    import avst_chan_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned IN_CHANNEL_W   = 1,
    parameter int unsigned OUT_CHANNEL_W  = 8,
    parameter int unsigned CHANNEL_OFFSET = 0,
    parameter int unsigned MAX_CHANNEL    = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [IN_CHANNEL_W-1:0]  in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OUT_CHANNEL_W-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [DROP_CNT_W-1:0]    drop_count
`ifdef AVST_PKT_CHECK_EN
    ,
    output logic                     proto_error
`endif
);

    localparam int unsigned CW = OUT_CHANNEL_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CW-1:0]     channel;
        logic              sop;
        logic              eop;
    } chan_beat_t;

    localparam logic [CW:0] OFFSET_EXT = (CW+1)'(CHANNEL_OFFSET);
    localparam logic [CW:0] MAX_EXT    = (CW+1)'(MAX_CHANNEL);

    chan_state_e             state_q, state_d;
    logic [CW-1:0]           lock_q, lock_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW:0]             mapped;
    logic                    out_of_range;
    logic                    accept, lock_sop, push, buf_ready;
    chan_beat_t              push_beat, buf_out;

    // The carry bit catches offsets that wrap the output channel width.
    assign mapped       = {{(CW+1-IN_CHANNEL_W){1'b0}}, in_channel} + OFFSET_EXT;
    assign out_of_range = mapped[CW] | (mapped > MAX_EXT);

    assign in_ready = ~reset & (buf_ready | (state_q == DROP));
    assign accept   = in_valid & in_ready;

`ifdef AVST_PKT_CHECK_EN
    logic proto_error_q, proto_error_d;
    assign proto_error = proto_error_q;
    assign lock_sop    = in_startofpacket & ((state_q == IDLE) | (state_q == PASS));
    assign proto_error_d = accept & (((state_q == IDLE) & ~in_startofpacket) |
                                     ((state_q == PASS) &  in_startofpacket));
`else
    assign lock_sop    = in_startofpacket & (state_q == IDLE);
`endif

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        drop_cnt_d = drop_cnt_q;
        push       = 1'b0;
        push_beat  = '{data: in_data, channel: lock_q,
                       sop: in_startofpacket, eop: in_endofpacket};
        if (accept) begin
            if (lock_sop) begin
                if (out_of_range) begin
                    if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
                    state_d = in_endofpacket ? IDLE : DROP;
                end else begin
                    push              = 1'b1;
                    push_beat.channel = mapped[CW-1:0];
                    lock_d            = mapped[CW-1:0];
                    state_d           = in_endofpacket ? IDLE : PASS;
                end
            end else begin
                unique case (state_q)
                    PASS: begin
                        push = 1'b1;
                        if (in_endofpacket) state_d = IDLE;
                    end
                    DROP: if (in_endofpacket) state_d = IDLE;
                    default: ;  // orphan beat in IDLE is discarded
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lock_q        <= '0;
            drop_cnt_q    <= '0;
`ifdef AVST_PKT_CHECK_EN
            proto_error_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            lock_q        <= lock_d;
            drop_cnt_q    <= drop_cnt_d;
`ifdef AVST_PKT_CHECK_EN
            proto_error_q <= proto_error_d;
`endif
        end
    end

    assign drop_count = drop_cnt_q;

    avst_skid_buffer #(
        .WIDTH($bits(chan_beat_t))
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (push),
        .in_ready (buf_ready),
        .in_data  (push_beat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign out_data          = buf_out.data;
    assign out_channel       = buf_out.channel;
    assign out_startofpacket = buf_out.sop;
    assign out_endofpacket   = buf_out.eop;

endmodule
